// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage of a classic five-stage RISC-V pipeline. It owns the
// fetch program counter and the IF/ID pipeline register.
//
// Ports
//   clk            in   rising-edge clock for all state
//   reset_n        in   synchronous reset, ACTIVE-HIGH (1 = reset); the name is
//                       historical, the polarity is not inverted
//   StallF         in   hold the PC register
//   StallD         in   hold the IF/ID register
//   FlushD         in   load a bubble into IF/ID
//   PCSrcE         in   taken branch/jump redirect from execute
//   PCTargetE[31:0]in   redirect target (bits [1:0] ignored)
//   InstrMemRdata  in   instruction memory data, combinational from InstrMemAddr
//   InstrMemAddr   out  instruction memory address (= PCF)
//   PCF            out  current fetch PC (always word aligned)
//   PCPlus4F       out  PCF + 4, wraps modulo 2^32
//   InstrD         out  registered instruction for decode
//   PCD            out  registered PC of InstrD
//   PCPlus4D       out  registered PC+4 of InstrD
//   ValidD         out  1 = InstrD is a fetched instruction, 0 = bubble
//
// Control priority
//   PC   : reset > PCSrcE redirect > StallF hold > sequential PC+4
//   IF/ID: reset > FlushD bubble   > StallD hold > load fetched instruction
// A redirect beats StallF so that a taken branch is never lost behind a
// load-use stall. With StallD=1 and StallF=0 the instruction fetched in that
// cycle is dropped; there is no skid buffer.
//
// No output is combinational from the control inputs: every output is either
// a register or a function of the PC register only.
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic [31:0] InstrMemRdata,
  output logic [31:0] InstrMemAddr,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  // -------------------------------------------------------------------------
  // PC register. Only the word address is stored, so PCF[1:0] is 2'b00 by
  // construction and misaligned targets simply lose their low bits.
  // -------------------------------------------------------------------------
  logic [29:0] pc_word_q;
  logic [29:0] pc_word_d;

  // Word-address increment: +1 on bits [31:2] equals +4 on the byte PC and
  // wraps 32'hFFFF_FFFC to 32'h0000_0000 naturally.
  logic [29:0] pc_word_plus1;

  assign pc_word_plus1 = pc_word_q + 30'd1;

  always_comb begin
    pc_word_d = pc_word_plus1;
    if (PCSrcE) begin
      pc_word_d = PCTargetE[31:2];
    end else if (StallF) begin
      pc_word_d = pc_word_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      pc_word_q <= RESET_PC[31:2];
    end else begin
      pc_word_q <= pc_word_d;
    end
  end

  assign PCF          = {pc_word_q, 2'b00};
  assign PCPlus4F     = {pc_word_plus1, 2'b00};
  assign InstrMemAddr = PCF;

  // -------------------------------------------------------------------------
  // IF/ID register
  // -------------------------------------------------------------------------
  logic [31:0] instr_q,  instr_d;
  logic [31:0] pc_d_q,   pc_d_d;
  logic [31:0] pc4_d_q,  pc4_d_d;
  logic        valid_q,  valid_d;

  always_comb begin
    // Default: load what is being fetched this cycle.
    instr_d = InstrMemRdata;
    pc_d_d  = PCF;
    pc4_d_d = PCPlus4F;
    valid_d = 1'b1;
    if (FlushD) begin
      instr_d = NOP_INSTR;
      pc_d_d  = 32'h0000_0000;
      pc4_d_d = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (StallD) begin
      instr_d = instr_q;
      pc_d_d  = pc_d_q;
      pc4_d_d = pc4_d_q;
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      instr_q <= NOP_INSTR;
      pc_d_q  <= 32'h0000_0000;
      pc4_d_q <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_d_q  <= pc_d_d;
      pc4_d_q <= pc4_d_d;
      valid_q <= valid_d;
    end
  end

  assign InstrD   = instr_q;
  assign PCD      = pc_d_q;
  assign PCPlus4D = pc4_d_q;
  assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage: a behavioural instruction memory, a cycle-level
// reference model of the PC and IF/ID contents, directed scenarios for the
// documented cases, then randomized control traffic.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic [31:0] InstrMemRdata;
  logic [31:0] InstrMemAddr, PCF, PCPlus4F, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .InstrMemRdata(InstrMemRdata), .InstrMemAddr(InstrMemAddr), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  // ---------------- instruction memory ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      default:       return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endcase
  endfunction

  assign InstrMemRdata = mem_word(InstrMemAddr);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model state: fetch PC and what decode should be holding.
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pcd   = 32'h0;
  logic [31:0] m_pc4d  = 32'h0;
  logic        m_valid = 1'b0;

  task automatic model_edge(input logic rst, sf, sd, fd, ps, input logic [31:0] tgt);
    logic [31:0] n_pc;
    if (rst) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pcd = 0; m_pc4d = 0; m_valid = 1'b0;
      return;
    end
    if (ps)      n_pc = tgt & 32'hFFFF_FFFC;
    else if (sf) n_pc = m_pc;
    else         n_pc = m_pc + 32'd4;
    if (fd) begin
      m_instr = NOP_INSTR; m_pcd = 0; m_pc4d = 0; m_valid = 1'b0;
    end else if (!sd) begin
      m_instr = mem_word(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_valid = 1'b1;
    end
    m_pc = n_pc;
  endtask

  task automatic check_all();
    check("PCF",          PCF,          m_pc);
    check("PCPlus4F",     PCPlus4F,     m_pc + 32'd4);
    check("InstrMemAddr", InstrMemAddr, m_pc);
    check("InstrD",       InstrD,       m_instr);
    check("PCD",          PCD,          m_pcd);
    check("PCPlus4D",     PCPlus4D,     m_pc4d);
    check("ValidD",       {31'd0, ValidD}, {31'd0, m_valid});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, sf, sd, fd, ps, input logic [31:0] tgt);
    @(negedge clk);
    reset_n = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    @(posedge clk);
    model_edge(rst, sf, sd, fd, ps, tgt);
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset
    step(1, 1, 1, 1, 1, 32'h0000_0080);
    step(1, 0, 0, 0, 0, 32'h0);
    check("rst_PCF", PCF, RESET_PC);
    check("rst_InstrD", InstrD, NOP_INSTR);

    // sequential fetch
    step(0, 0, 0, 0, 0, 32'h0);
    check("seq1_InstrD", InstrD, 32'h0050_0093);
    check("seq1_PCPlus4D", PCPlus4D, 32'h4);
    step(0, 0, 0, 0, 0, 32'h0);
    check("seq2_InstrD", InstrD, 32'h00A0_0113);
    check("seq2_PCD", PCD, 32'h4);

    // load-use stall at PCF=8, then resume
    step(0, 1, 1, 0, 0, 32'h0);
    check("stall_PCF", PCF, 32'h8);
    check("stall_PCD", PCD, 32'h4);
    step(0, 0, 0, 0, 0, 32'h0);
    check("resume_PCF", PCF, 32'hC);

    // taken branch with flush
    step(0, 0, 0, 1, 1, 32'h0000_0040);
    check("br_PCF", PCF, 32'h40);
    check("br_InstrD", InstrD, NOP_INSTR);
    step(0, 0, 0, 0, 0, 32'h0);
    check("br_PCD", PCD, 32'h40);

    // priority: redirect beats StallF, flush beats StallD
    step(0, 1, 0, 0, 1, 32'h0000_0103);
    check("prio_PCF", PCF, 32'h100);
    step(0, 0, 1, 1, 0, 32'h0);
    check("prio_ValidD", {31'd0, ValidD}, 32'd0);

    // address wrap
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    check("wrap_PCPlus4F", PCPlus4F, 32'h0);
    step(0, 0, 0, 0, 0, 32'h0);
    check("wrap_PCF", PCF, 32'h0);

    // reset during a stall at PCF=0x20, then first fetch after release
    step(0, 0, 0, 1, 1, 32'h0000_0020);
    step(0, 1, 1, 0, 0, 32'h0);
    check("mid_PCF", PCF, 32'h20);
    step(1, 1, 1, 0, 1, 32'h0000_0080);
    check("midrst_PCF", PCF, RESET_PC);
    step(0, 0, 0, 0, 0, 32'h0);
    check("post_rst_InstrD", InstrD, mem_word(RESET_PC));
    check("post_rst_ValidD", {31'd0, ValidD}, 32'd1);

    // randomized control traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom();
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | ($urandom() & 32'hF);
      step(($urandom_range(0, 39) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0),
           tgt);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset (bits [1:0] = 00).
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction inserted on flush/reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 reset_n  in  1  synchronous reset, active-high (1 = reset), sampled on clk rising edge.
REQ-006 StallF  in  1  hold PC register.
REQ-007 StallD  in  1  hold IF/ID register.
REQ-008 FlushD  in  1  replace IF/ID contents with bubble.
REQ-009 PCSrcE  in  1  taken branch/jump redirect from execute.
REQ-010 PCTargetE  in  32  redirect target from execute.
REQ-011 InstrMemRdata  in  32  instruction memory read data, combinational from InstrMemAddr.
REQ-012 InstrMemAddr  out  32  instruction memory address, equal to PCF.
REQ-013 PCF  out  32  current fetch PC.
REQ-014 PCPlus4F  out  32  PCF + 4, combinational.
REQ-015 InstrD  out  32  registered instruction to decode (InstrD[19:15], [24:20], [11:7] used as Rs1/Rs2/Rd).
REQ-016 PCD  out  32  registered PC of InstrD.
REQ-017 PCPlus4D  out  32  registered PCF+4 of InstrD.
REQ-018 ValidD  out  1  1 = InstrD is a real fetched instruction, 0 = bubble.

Function
REQ-019 PCPlus4F SHALL be PCF + 32'd4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-020 PC next-value priority SHALL be: reset -> RESET_PC; else PCSrcE=1 -> {PCTargetE[31:2],2'b00}; else StallF=1 -> hold; else PCPlus4F.
REQ-021 PCSrcE SHALL override StallF (redirect is never lost).
REQ-022 PCF[1:0] SHALL always be 2'b00; PCTargetE[1:0] are ignored.
REQ-023 IF/ID next-value priority SHALL be: reset -> bubble; else FlushD=1 -> bubble; else StallD=1 -> hold all IF/ID fields; else load {InstrMemRdata, PCF, PCPlus4F, ValidD=1}.
REQ-024 Bubble SHALL mean InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
REQ-025 FlushD SHALL override StallD.
REQ-026 Fetch-to-decode latency SHALL be exactly 1 cycle: instruction at PCF in cycle n appears on InstrD in cycle n+1 when not stalled/flushed.
REQ-027 When StallF=1 and StallD=1 (load-use), PCF and all IF/ID outputs SHALL hold unchanged for that cycle.
REQ-028 When PCSrcE=1 together with FlushD=1, the next cycle SHALL show PCF=target and ValidD=0; the target instruction appears on InstrD one cycle later.
REQ-029 StallD=1 with StallF=0 SHALL be legal; the instruction fetched in that cycle is dropped (no buffering).
REQ-030 No output SHALL depend combinationally on StallF, StallD, FlushD, PCSrcE or PCTargetE except through registered state.

Reset
REQ-031 While reset_n=1 at a clk edge: PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, regardless of all other inputs.
REQ-032 Reset mid-stall or mid-redirect SHALL win; first fetch after reset release is from RESET_PC, appearing on InstrD with ValidD=1 one cycle after release.
REQ-033 No state SHALL change asynchronously to clk.

Verification
REQ-034 Sequential fetch: reset then release, memory returns 32'h00500093 at 0 and 32'h00A00113 at 4 -> cycle1 InstrD=00500093, PCD=0, PCPlus4D=4, ValidD=1; cycle2 InstrD=00A00113, PCD=4.
REQ-035 Load-use stall: StallF=StallD=1 for one cycle at PCF=8 -> PCF stays 8 and InstrD/PCD unchanged for that cycle, then fetch resumes at 12.
REQ-036 Taken branch: PCSrcE=1, PCTargetE=32'h0000_0040, FlushD=1 -> next cycle PCF=40, ValidD=0, InstrD=00000013; following cycle PCD=40, ValidD=1.
REQ-037 Priority: StallF=1 with PCSrcE=1, PCTargetE=32'h0000_0103 -> PCF=32'h0000_0100; FlushD=1 with StallD=1 -> bubble loaded.
REQ-038 Wrap: PCF=32'hFFFF_FFFC -> PCPlus4F=0 and next PCF=0.
REQ-039 Reset mid-operation: assert reset_n=1 during a stall with PCF=32'h0000_0020 -> next cycle PCF=RESET_PC, ValidD=0.
